// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared pipeline types for the ID/EXE issue controller and its helpers.
package hazard_issue_ctrl_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned HOLD_CNT_W = 2;

  // Destination-tracking payload carried by one pipeline stage.
  typedef struct packed {
    logic [REG_W-1:0] num_write;
    logic             reg_write;
    logic             mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '{num_write: '0, reg_write: 1'b0, mem_read: 1'b0};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Build a slot; a write to $0 is architecturally a no-op, so drop it here.
  function automatic slot_t make_slot(input logic [REG_W-1:0] num_write,
                                      input logic             reg_write,
                                      input logic             mem_read);
    slot_t s;
    s.num_write = num_write;
    s.reg_write = reg_write & (num_write != '0);
    s.mem_read  = mem_read;
    return s;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source-operand match against one stage's destination; $0 never matches.
module hazard_cmp
  import hazard_issue_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [REG_W-1:0] num_write,
  input  logic             reg_write,
  output logic             hit_c
);

  logic dst_live;
  logic rs_hit;
  logic rt_hit;

  // Compare each used source against a live, non-zero destination.
  always_comb begin
    dst_live = reg_write & (num_write != '0);
    rs_hit   = uses_rs & (rs == num_write);
    rt_hit   = uses_rt & (rt == num_write);
    hit_c    = dst_live & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/hazard_issue_ctrl.sv
// ID/EXE issue controller: load-use interlock, flush squash, EXE/MEM tracking.
module hazard_issue_ctrl
  import hazard_issue_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_num_write,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [REG_W-1:0] EXE_num_write,
  output logic             EXE_reg_write,
  output logic             EXE_mem_read,
  output logic [REG_W-1:0] MEM_num_write,
  output logic             MEM_reg_write,
  output logic [CNT_W-1:0] stall_cycles
);

  // Extra bubbles beyond the first one, loaded into the HOLD counter.
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(LOAD_LATENCY - 1);
  localparam bit                    MULTI_BUBBLE = (LOAD_LATENCY > 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [HOLD_CNT_W-1:0]   cnt_q;
  logic [HOLD_CNT_W-1:0]   cnt_d;
  slot_t                   exe_q;
  slot_t                   exe_d;
  logic [REG_W-1:0]        mem_num_write_q;
  logic                    mem_reg_write_q;
  logic [CNT_W-1:0]        stall_cycles_q;
  logic                    exe_hit_c;
  logic                    hazard_c;
  logic                    issue_c;

  hazard_cmp u_exe_cmp (
    .rs        (rs),
    .rt        (rt),
    .uses_rs   (id_uses_rs),
    .uses_rt   (id_uses_rt),
    .num_write (exe_q.num_write),
    .reg_write (exe_q.reg_write),
    .hit_c     (exe_hit_c)
  );

  // Only a load in EXE forces an interlock; other writers are forwarded.
  always_comb begin
    hazard_c = id_valid & exe_q.mem_read & exe_hit_c;
  end

  // FSM state and bubble-countdown registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall decode; flush always overrides the interlock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = hazard_c & ~flush;
        if (stall && MULTI_BUBBLE) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        stall = ~flush;
        if (flush) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - HOLD_CNT_W'(1);
          if (cnt_q == HOLD_CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  // Next EXE slot: the ID instruction if it issues, otherwise a bubble.
  always_comb begin
    issue_c = id_valid & ~stall & ~flush;
    exe_d   = BUBBLE;
    if (issue_c) begin
      exe_d = make_slot(id_num_write, id_reg_write, id_mem_read);
    end
  end

  // EXE and MEM destination tracking; MEM always advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      exe_q           <= BUBBLE;
      mem_num_write_q <= '0;
      mem_reg_write_q <= 1'b0;
    end else begin
      exe_q           <= exe_d;
      mem_num_write_q <= exe_q.num_write;
      mem_reg_write_q <= exe_q.reg_write;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign EXE_num_write = exe_q.num_write;
  assign EXE_reg_write = exe_q.reg_write;
  assign EXE_mem_read  = exe_q.mem_read;
  assign MEM_num_write = mem_num_write_q;
  assign MEM_reg_write = mem_reg_write_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: doc/hazard_issue_ctrl.md
Name: hazard_issue_ctrl

Overview:
- ID/EXE boundary controller of the 5-stage pipeline; producing end of the register-forwarding interface.
- Each cycle it decides whether the decoded instruction issues into EXE, or whether a bubble is inserted while IF/ID are held (load-use interlock).
- It owns the EXE and MEM destination-tracking registers and drives EXE_num_write/EXE_reg_write to the forwarding unit.
- Branch flush squashes the issuing slot.

Parameters:
- LOAD_LATENCY, 1: bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- rs  input  5  ID source register A.
- rt  input  5  ID source register B.
- id_uses_rs  input  1  instruction reads rs.
- id_uses_rt  input  1  instruction reads rt.
- id_num_write  input  5  ID destination register.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  taken branch/jump; squash the ID instruction.
- stall  output  1  hold PC and IF/ID register this cycle; combinational.
- EXE_num_write  output  5  destination of the instruction in EXE.
- EXE_reg_write  output  1  EXE instruction writes the register file.
- EXE_mem_read  output  1  EXE instruction is a load.
- MEM_num_write  output  5  destination in MEM.
- MEM_reg_write  output  1  MEM instruction writes the register file.
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (synchronous, wins over everything): all EXE_*/MEM_* outputs, stall_cycles, and the internal counter cnt go to 0; FSM goes to RUN. stall reads 0 in the cycle after reset.
- Bubble is defined as num_write=0, reg_write=0, mem_read=0.
- hazard = id_valid & EXE_mem_read & EXE_reg_write & (EXE_num_write!=0) & ((id_uses_rs & rs==EXE_num_write) | (id_uses_rt & rt==EXE_num_write)).
- Register $0 never causes a hazard.
- FSM states: RUN, HOLD. cnt width is 2 bits.
- RUN:
  - stall = hazard & ~flush.
  - If stall and LOAD_LATENCY>1: next state HOLD, cnt <= LOAD_LATENCY-1.
  - Otherwise stay in RUN.
- HOLD:
  - stall = ~flush.
  - cnt decrements each cycle; when cnt==1, next state RUN.
  - If flush is asserted: next state RUN, cnt <= 0.
- EXE slot update, every clock:
  - If stall, flush, or ~id_valid: EXE slot <= bubble.
  - Else: EXE slot <= {id_num_write, id_reg_write & (id_num_write!=0), id_mem_read}.
- MEM slot update: MEM slot <= EXE slot every clock; no stall ever applies to MEM.
- Latency: instruction accepted at edge N appears on EXE_* after edge N and on MEM_* after edge N+1.
- Simultaneous flush and hazard: flush wins.
  - stall=0, bubble inserted, no HOLD entered.
  - Flushing the front end already removes the dependent instruction.
- Hazard on a non-load EXE writer: no stall; the forwarding unit resolves it.
- stall_cycles: +1 on each clock with stall=1; saturates at all-ones and never wraps.
- Reset mid-HOLD: returns to RUN, stall=0 next cycle, slots cleared; no residual bubbles.
- id_valid=0 with a matching rs: no stall (hazard is gated by id_valid).

Decomposition:
- Shared pipeline package holds:
  - REG_W=5 constant.
  - Stage-slot struct {num_write, reg_write, mem_read}.
  - BUBBLE constant.
  - FSM state enum {RUN, HOLD}.
- One natural sub-module, hazard_cmp: combinational match of rs/rt against one slot, gated by the use bits and the non-zero check. Instantiated once for EXE; reusable later for MEM-stage branch compares.

Test Plan:
- LOAD_LATENCY=1: load to $5 issues, then ADD using rs=$5 next cycle -> stall=1 for exactly 1 cycle; EXE_* = bubble (0,0,0) that cycle; ADD enters EXE the following cycle; stall_cycles=1.
- LOAD_LATENCY=3: same sequence -> stall high 3 consecutive cycles, FSM RUN->HOLD->HOLD->RUN; stall_cycles=3.
- Load to $0, consumer uses rs=$0 -> no stall; EXE_reg_write=0 for the load.
- ALU write to $7, then consumer of $7 -> no stall; EXE_num_write=7, EXE_reg_write=1, MEM_num_write=7 one cycle later.
- Hazard and flush in the same cycle, and flush during HOLD cycle 2 of 3 -> stall=0 immediately, EXE bubble, FSM RUN, no further stall.
- Reset asserted during HOLD; also force stall_cycles to saturate with CNT_W=4 -> all outputs 0 after the reset edge; counter holds at 15.
